// File: rtl/chroma_pkg.sv
// rtl/chroma_pkg.sv - shared types and constants for the colour-burst phase detector
//
// Purpose: sample/accumulator widths, saturation limits, default burst timing,
//          the detector FSM state type and the mixer scale/saturate helper.
// Ports:   none (package).
package chroma_pkg;

  localparam int SAMPLE_W        = 12;
  localparam int OFFSET_W        = 32;
  localparam int SCALE_SHIFT     = 11;
  localparam int DEF_START_DELAY = 394;
  localparam int DEF_BURST_LEN   = 148;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 12'sh7FF;   //  2047
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 12'sh800;   // -2048

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_GATE  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Arithmetic shift right by SCALE_SHIFT, then clamp to the sample range.
  // The shifted product of two 12-bit samples fits in 13 bits, so the
  // result overflows exactly when its top two bits differ.
  function automatic logic signed [SAMPLE_W-1:0] sat_scale(
    input logic signed [2*SAMPLE_W-1:0] p
  );
    logic [SAMPLE_W:0] t;
    t = p[SCALE_SHIFT+SAMPLE_W:SCALE_SHIFT];
    if (t[SAMPLE_W] == t[SAMPLE_W-1]) begin
      return t[SAMPLE_W-1:0];
    end else if (t[SAMPLE_W]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/burst_mixer.sv
// rtl/burst_mixer.sv - two-stage signed mixer: multiply, scale by 2^-11, saturate
//
// Purpose: o_mix = sat12((i_sample * i_ref) >>> 11), two register stages.
// Ports:   clk      - system clock
//          rst_n    - asynchronous active-low reset
//          i_sample - 12-bit signed video sample
//          i_ref    - 12-bit signed NCO reference
//          o_mix    - 12-bit signed scaled, saturated product (2-clock latency)
module burst_mixer
  import chroma_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] i_ref,
  output logic signed [SAMPLE_W-1:0] o_mix
);

  logic signed [2*SAMPLE_W-1:0] w_a_ext;
  logic signed [2*SAMPLE_W-1:0] w_b_ext;
  logic signed [2*SAMPLE_W-1:0] r_prod;
  logic signed [SAMPLE_W-1:0]   r_mix;

  assign w_a_ext = {{SAMPLE_W{i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_b_ext = {{SAMPLE_W{i_ref[SAMPLE_W-1]}}, i_ref};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_mix  <= '0;
    end else begin
      r_prod <= w_a_ext * w_b_ext;
      r_mix  <= sat_scale(r_prod);
    end
  end

  assign o_mix = r_mix;

endmodule

// File: rtl/burst_phase_detector.sv
// rtl/burst_phase_detector.sv - colour-burst gate, phase error and burst-present detector
//
// Purpose: after each hsync rising edge, wait START_DELAY clocks, gate BURST_LEN
//          samples, output the quadrature phase error during the gate, accumulate
//          the in-phase product into a per-line burst amplitude and drive a
//          hysteresis colour-killer flag.
// Ports:   clk           - system clock
//          rst_n         - asynchronous active-low reset
//          hsync_in      - separated horizontal sync, active-high
//          video_in      - 12-bit signed DC-removed composite sample
//          nco_sin       - 12-bit signed NCO quadrature reference
//          nco_cos       - 12-bit signed NCO in-phase reference
//          burst_active  - gate aligned with error_out
//          error_out     - 12-bit signed per-sample phase error (0 outside gate)
//          burst_amp     - 16-bit magnitude of the last completed burst
//          burst_present - colour-killer flag with hysteresis
module burst_phase_detector
  import chroma_pkg::*;
#(
  parameter int START_DELAY = DEF_START_DELAY,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int AMP_THRESH  = 2000,
  parameter int HYST_LINES  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hsync_in,
  input  logic signed [SAMPLE_W-1:0] video_in,
  input  logic signed [SAMPLE_W-1:0] nco_sin,
  input  logic signed [SAMPLE_W-1:0] nco_cos,
  output logic                       burst_active,
  output logic signed [SAMPLE_W-1:0] error_out,
  output logic [15:0]                burst_amp,
  output logic                       burst_present
);

  localparam int CNT_W  = 16;
  localparam int HYST_W = $clog2(HYST_LINES + 1);

  localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0]  GATE_LAST  = CNT_W'(BURST_LEN - 1);
  // DONE waits two extra clocks so the last gated sample leaves the mixer
  // pipeline and lands in the accumulator before the amplitude is taken.
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(2);
  localparam logic [HYST_W-1:0] HYST_MAX   = HYST_W'(HYST_LINES);
  localparam logic [HYST_W-1:0] HYST_ONE   = HYST_W'(1);
  localparam logic [15:0]       AMP_LIMIT  = 16'(AMP_THRESH);

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_hsync_d;
  logic                        r_armed;
  logic                        r_hs_edge;
  logic                        r_gate_d1;
  logic                        r_gate_d2;
  logic signed [OFFSET_W-1:0]  r_acc;
  logic [15:0]                 r_amp;
  logic [HYST_W-1:0]           r_up;
  logic [HYST_W-1:0]           r_dn;
  logic                        r_present;

  logic signed [SAMPLE_W-1:0]  w_q;
  logic signed [SAMPLE_W-1:0]  w_i;
  logic signed [OFFSET_W-1:0]  w_i_ext;
  logic [OFFSET_W-1:0]         w_acc_abs;
  logic [15:0]                 w_amp_new;
  logic                        w_line_seen;

  burst_mixer u_mix_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (video_in),
    .i_ref    (nco_sin),
    .o_mix    (w_q)
  );

  burst_mixer u_mix_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (video_in),
    .i_ref    (nco_cos),
    .o_mix    (w_i)
  );

  assign w_i_ext     = {{(OFFSET_W-SAMPLE_W){w_i[SAMPLE_W-1]}}, w_i};
  assign w_acc_abs   = r_acc[OFFSET_W-1] ? $unsigned(-r_acc) : $unsigned(r_acc);
  assign w_amp_new   = (|w_acc_abs[OFFSET_W-1:16]) ? 16'hFFFF : w_acc_abs[15:0];
  assign w_line_seen = (w_amp_new > AMP_LIMIT);

  // Edge detect and gate alignment. r_armed blocks a level that is already
  // high when reset releases from being taken as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_d <= 1'b0;
      r_armed   <= 1'b0;
      r_hs_edge <= 1'b0;
      r_gate_d1 <= 1'b0;
      r_gate_d2 <= 1'b0;
    end else begin
      r_hsync_d <= hsync_in;
      r_armed   <= 1'b1;
      r_hs_edge <= hsync_in & ~r_hsync_d & r_armed;
      r_gate_d1 <= (r_state == ST_GATE);
      r_gate_d2 <= r_gate_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_amp     <= '0;
      r_up      <= '0;
      r_dn      <= '0;
      r_present <= 1'b0;
    end else begin
      if (r_gate_d2) begin
        r_acc <= r_acc + w_i_ext;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_hs_edge) begin
            r_state <= ST_DELAY;
            r_cnt   <= '0;
          end
        end
        ST_DELAY: begin
          if (r_cnt == DELAY_LAST) begin
            r_state <= ST_GATE;
            r_cnt   <= '0;
            r_acc   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GATE: begin
          if (r_cnt == GATE_LAST) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (r_cnt == DRAIN_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_amp   <= w_amp_new;
            if (w_line_seen) begin
              r_dn <= '0;
              if (r_up != HYST_MAX) r_up <= r_up + HYST_ONE;
              if (r_up >= HYST_MAX - HYST_ONE) r_present <= 1'b1;
            end else begin
              r_up <= '0;
              if (r_dn != HYST_MAX) r_dn <= r_dn + HYST_ONE;
              if (r_dn >= HYST_MAX - HYST_ONE) r_present <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign burst_active  = r_gate_d2;
  assign error_out     = r_gate_d2 ? w_q : '0;
  assign burst_amp     = r_amp;
  assign burst_present = r_present;

endmodule
